// File: rtl/seg7_reader.sv
// Recovers hex digits from a multiplexed active-low 7-segment bus and assembles them into one word.
// Latency: a pattern that first appears at the synchronizer output at edge t is captured at edge t+1+STABLE_CYCLES.
// Backpressure: one frame register only; captures that arrive while a frame is pending are dropped and flagged on drop_o.
module seg7_reader #(
    parameter int NUM_DIGITS    = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [0:6]              seg_n,
    input  logic [NUM_DIGITS-1:0]   dig_n,
    output logic [4*NUM_DIGITS-1:0] value_o,
    output logic                    err_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    drop_o
);

    localparam int                    CW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]         CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0]         CNT_CAP = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0]         CNT_ONE = CW'(1);
    localparam logic [NUM_DIGITS-1:0] DIG_ONE = NUM_DIGITS'(1);

    typedef enum logic {
        COLLECT = 1'b0,
        PRESENT = 1'b1
    } state_t;

    // Synchronizer chain plus one extra stage holding the previous synchronized sample.
    logic [0:6]            seg_s1_q, seg_s1_d;
    logic [0:6]            seg_s2_q, seg_s2_d;
    logic [0:6]            seg_p_q,  seg_p_d;
    logic [NUM_DIGITS-1:0] dig_s1_q, dig_s1_d;
    logic [NUM_DIGITS-1:0] dig_s2_q, dig_s2_d;
    logic [NUM_DIGITS-1:0] dig_p_q,  dig_p_d;

    // Stability tracking.
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  same_w;
    logic                  qual_w;
    logic                  capture_w;
    logic [NUM_DIGITS-1:0] sel_oh_w;

    // Decoded digit from the current synchronized sample.
    logic [3:0]            dec_nib_w;
    logic                  dec_bad_w;

    // Frame assembly state.
    state_t                      state_q, state_d;
    logic [NUM_DIGITS-1:0][3:0]  slot_nib_q, slot_nib_d;
    logic [NUM_DIGITS-1:0]       slot_bad_q, slot_bad_d;
    logic [NUM_DIGITS-1:0]       mask_q, mask_d;
    logic [NUM_DIGITS-1:0]       mask_set_w;
    logic                        frame_done_w;
    logic [4*NUM_DIGITS-1:0]     value_q, value_d;
    logic                        err_q, err_d;
    logic                        valid_q, valid_d;
    logic                        drop_q, drop_d;

    // Shift the raw pins through the synchronizer and keep the previous sample for comparison.
    always_comb begin
        seg_s1_d = seg_n;
        seg_s2_d = seg_s1_q;
        seg_p_d  = seg_s2_q;
        dig_s1_d = dig_n;
        dig_s2_d = dig_s1_q;
        dig_p_d  = dig_s2_q;
    end

    // A sample is usable only when exactly one digit enable is low; equal-to-previous drives the counter.
    always_comb begin
        sel_oh_w  = ~dig_s2_q;
        qual_w    = (sel_oh_w != '0) && ((sel_oh_w & (sel_oh_w - DIG_ONE)) == '0);
        same_w    = (seg_s2_q == seg_p_q) && (dig_s2_q == dig_p_q);
        capture_w = qual_w && same_w && (cnt_q == CNT_CAP);
        cnt_d     = cnt_q;
        if (!qual_w || !same_w) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Map a lit-segment pattern (a..g, active low) back to its hex nibble; anything else is flagged.
    always_comb begin
        dec_nib_w = 4'h0;
        dec_bad_w = 1'b0;
        case (seg_s2_q)
            7'b0000001: dec_nib_w = 4'h0;
            7'b1001111: dec_nib_w = 4'h1;
            7'b0010010: dec_nib_w = 4'h2;
            7'b0000110: dec_nib_w = 4'h3;
            7'b1001100: dec_nib_w = 4'h4;
            7'b0100100: dec_nib_w = 4'h5;
            7'b0100000: dec_nib_w = 4'h6;
            7'b0001111: dec_nib_w = 4'h7;
            7'b0000000: dec_nib_w = 4'h8;
            7'b0001100: dec_nib_w = 4'h9;
            7'b0001000: dec_nib_w = 4'hA;
            7'b1100000: dec_nib_w = 4'hB;
            7'b0110001: dec_nib_w = 4'hC;
            7'b1000010: dec_nib_w = 4'hD;
            7'b0110000: dec_nib_w = 4'hE;
            7'b0111000: dec_nib_w = 4'hF;
            default:    dec_bad_w = 1'b1;
        endcase
    end

    // The frame completes when this capture fills the last missing digit.
    always_comb begin
        mask_set_w   = mask_q | sel_oh_w;
        frame_done_w = capture_w && (&mask_set_w);
    end

    // Synchronizer and stability counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1_q <= '1;
            seg_s2_q <= '1;
            seg_p_q  <= '1;
            dig_s1_q <= '1;
            dig_s2_q <= '1;
            dig_p_q  <= '1;
            cnt_q    <= '0;
        end else begin
            seg_s1_q <= seg_s1_d;
            seg_s2_q <= seg_s2_d;
            seg_p_q  <= seg_p_d;
            dig_s1_q <= dig_s1_d;
            dig_s2_q <= dig_s2_d;
            dig_p_q  <= dig_p_d;
            cnt_q    <= cnt_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: leave COLLECT on a completing capture, leave PRESENT on the output handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (frame_done_w) state_d = PRESENT;
            PRESENT: if (valid_q && ready_i) state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // FSM outputs: fill slots while collecting, publish the frame on completion, drop captures while presenting.
    always_comb begin
        slot_nib_d = slot_nib_q;
        slot_bad_d = slot_bad_q;
        mask_d     = mask_q;
        value_d    = value_q;
        err_d      = err_q;
        valid_d    = valid_q;
        drop_d     = 1'b0;
        case (state_q)
            COLLECT: begin
                if (capture_w) begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (sel_oh_w[i]) begin
                            slot_nib_d[i] = dec_nib_w;
                            slot_bad_d[i] = dec_bad_w;
                        end
                    end
                    mask_d = mask_set_w;
                    if (frame_done_w) begin
                        for (int i = 0; i < NUM_DIGITS; i++) begin
                            value_d[4*i +: 4] = slot_nib_d[i];
                        end
                        err_d   = |slot_bad_d;
                        valid_d = 1'b1;
                        mask_d  = '0;
                    end
                end
            end
            PRESENT: begin
                if (capture_w) begin
                    drop_d = 1'b1;
                end
                if (valid_q && ready_i) begin
                    valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Slot, mask and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_nib_q <= '0;
            slot_bad_q <= '0;
            mask_q     <= '0;
            value_q    <= '0;
            err_q      <= 1'b0;
            valid_q    <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            slot_nib_q <= slot_nib_d;
            slot_bad_q <= slot_bad_d;
            mask_q     <= mask_d;
            value_q    <= value_d;
            err_q      <= err_d;
            valid_q    <= valid_d;
            drop_q     <= drop_d;
        end
    end

    assign value_o = value_q;
    assign err_o   = err_q;
    assign valid_o = valid_q;
    assign drop_o  = drop_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader: reset, frame assembly, stability timing, invalid patterns, overwrite, drop and mid-frame reset.
// Inputs change 1 time unit after the rising edge; outputs are read at the falling edge or 1 unit after the rising edge.
// Each scenario task carries its own comparisons and bumps the shared counters.
module tb_seg7_reader;

    localparam int ND = 2;
    localparam int SC = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [0:6]    seg_n;
    logic [ND-1:0] dig_n;
    logic [7:0]    value_o;
    logic          err_o;
    logic          valid_o;
    logic          ready_i;
    logic          drop_o;

    int n_cmp = 0;
    int n_bad = 0;
    int drop_cnt;
    bit valid_seen;

    always #5 clk = ~clk;

    seg7_reader #(
        .NUM_DIGITS   (ND),
        .STABLE_CYCLES(SC)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .seg_n  (seg_n),
        .dig_n  (dig_n),
        .value_o(value_o),
        .err_o  (err_o),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .drop_o (drop_o)
    );

    // Hold one pin pattern for n clock edges, watching drop_o and valid_o at each falling edge.
    task automatic drive(input logic [1:0] d, input logic [0:6] s, input int n);
        dig_n = d;
        seg_n = s;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (drop_o === 1'b1) drop_cnt++;
            if (valid_o === 1'b1) valid_seen = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        drive(2'b11, 7'b1111111, n);
    endtask

    task automatic clear_mon();
        drop_cnt   = 0;
        valid_seen = 1'b0;
    endtask

    task automatic pulse_ready();
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        ready_i = 1'b0;
        dig_n   = 2'b11;
        seg_n   = 7'b1111111;
        clear_mon();
        repeat (3) @(negedge clk);
        n_cmp++; if (value_o !== 8'h00) begin n_bad++; $display("FAIL reset_value got=%h want=00", value_o); end
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b want=0", err_o); end
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b want=0", valid_o); end
        n_cmp++; if (drop_o !== 1'b0) begin n_bad++; $display("FAIL reset_drop got=%b want=0", drop_o); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(20);
        n_cmp++; if (valid_seen !== 1'b0) begin n_bad++; $display("FAIL idle_no_valid got=%b want=0", valid_seen); end
    endtask

    task automatic test_basic();
        clear_mon();
        drive(2'b10, 7'b0010010, 6);
        drive(2'b01, 7'b0001000, 6);
        idle(10);
        n_cmp++; if (valid_o !== 1'b1) begin n_bad++; $display("FAIL basic_valid got=%b want=1", valid_o); end
        n_cmp++; if (value_o !== 8'hA2) begin n_bad++; $display("FAIL basic_value got=%h want=a2", value_o); end
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL basic_err got=%b want=0", err_o); end
        idle(8);
        n_cmp++; if (valid_o !== 1'b1) begin n_bad++; $display("FAIL basic_hold_valid got=%b want=1", valid_o); end
        n_cmp++; if (value_o !== 8'hA2) begin n_bad++; $display("FAIL basic_hold_value got=%h want=a2", value_o); end
        n_cmp++; if (drop_cnt !== 0) begin n_bad++; $display("FAIL basic_no_drop got=%0d want=0", drop_cnt); end
        pulse_ready();
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL basic_handshake got=%b want=0", valid_o); end
    endtask

    task automatic test_invalid();
        clear_mon();
        drive(2'b10, 7'b1111111, 6);
        idle(3);
        drive(2'b01, 7'b1001111, 6);
        idle(10);
        n_cmp++; if (valid_o !== 1'b1) begin n_bad++; $display("FAIL inv_valid got=%b want=1", valid_o); end
        n_cmp++; if (value_o !== 8'h10) begin n_bad++; $display("FAIL inv_value got=%h want=10", value_o); end
        n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL inv_err got=%b want=1", err_o); end
        pulse_ready();
    endtask

    task automatic test_overwrite();
        clear_mon();
        drive(2'b10, 7'b0100100, 6);
        idle(3);
        drive(2'b10, 7'b0110000, 6);
        idle(3);
        // Both enables low with a legal pattern on the bus must not count as any digit.
        drive(2'b00, 7'b0001111, 10);
        idle(3);
        n_cmp++; if (valid_seen !== 1'b0) begin n_bad++; $display("FAIL ovw_multi_sel got=%b want=0", valid_seen); end
        drive(2'b01, 7'b0000110, 6);
        idle(10);
        n_cmp++; if (valid_o !== 1'b1) begin n_bad++; $display("FAIL ovw_valid got=%b want=1", valid_o); end
        n_cmp++; if (value_o !== 8'h3E) begin n_bad++; $display("FAIL ovw_value got=%h want=3e", value_o); end
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL ovw_err got=%b want=0", err_o); end
        pulse_ready();
    endtask

    task automatic test_stability();
        clear_mon();
        // Three cycles of digit 0 is too short to capture.
        drive(2'b10, 7'b0000001, 3);
        idle(10);
        drive(2'b01, 7'b0001111, 6);
        idle(10);
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL stab_short got=%b want=0", valid_o); end
        // Pins sampled at edges 1..5 reach the synchronizer output at edge 2, so capture lands on edge 2+1+4 = 7.
        drive(2'b10, 7'b0000001, 5);
        idle(1);
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL stab_early got=%b want=0 at edge 6", valid_o); end
        idle(1);
        n_cmp++; if (valid_o !== 1'b1) begin n_bad++; $display("FAIL stab_edge7 got=%b want=1", valid_o); end
        n_cmp++; if (value_o !== 8'h70) begin n_bad++; $display("FAIL stab_value got=%h want=70", value_o); end
    endtask

    task automatic test_drop();
        // Frame 8'h70 is still pending here; a long stable digit is captured once and discarded.
        clear_mon();
        drive(2'b10, 7'b0000001, 50);
        idle(10);
        n_cmp++; if (drop_cnt !== 1) begin n_bad++; $display("FAIL drop_once got=%0d pulses want=1", drop_cnt); end
        n_cmp++; if (value_o !== 8'h70) begin n_bad++; $display("FAIL drop_value got=%h want=70", value_o); end
        n_cmp++; if (valid_o !== 1'b1) begin n_bad++; $display("FAIL drop_valid got=%b want=1", valid_o); end
        pulse_ready();
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL drop_handshake got=%b want=0", valid_o); end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        drive(2'b10, 7'b0001111, 6);
        idle(3);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL rmid_valid got=%b want=0", valid_o); end
        n_cmp++; if (value_o !== 8'h00) begin n_bad++; $display("FAIL rmid_value got=%h want=00", value_o); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(2'b01, 7'b0001100, 6);
        idle(10);
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL rmid_stale got=%b want=0", valid_o); end
        drive(2'b10, 7'b1001111, 6);
        idle(10);
        n_cmp++; if (valid_o !== 1'b1) begin n_bad++; $display("FAIL rmid_frame_valid got=%b want=1", valid_o); end
        n_cmp++; if (value_o !== 8'h91) begin n_bad++; $display("FAIL rmid_frame_value got=%h want=91", value_o); end
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL rmid_frame_err got=%b want=0", err_o); end
        pulse_ready();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_invalid();
        test_overwrite();
        test_stability();
        test_drop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
